// File: rtl/debug_cmd_sequencer.sv
// debug_cmd_sequencer: UART command decoder that loads instruction memory,
// controls run/step/stop of the pipeline and dumps pipeline state bytes.
module debug_cmd_sequencer #(
    parameter int MAX_INSTRUCTION = 64,
    parameter int ADDR_WIDTH      = 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_start,
    input  logic                  i_tx_done,
    output logic                  o_imem_we,
    output logic [ADDR_WIDTH-1:0] o_imem_addr,
    output logic [31:0]           o_imem_wdata,
    output logic                  o_cpu_rst,
    output logic                  o_cpu_stall,
    input  logic                  i_halt,
    output logic [2:0]            o_dump_sel,
    output logic [6:0]            o_dump_idx,
    input  logic [7:0]            i_dump_byte,
    output logic                  o_step_mode,
    output logic [3:0]            o_state
);
    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        LOAD_CNT   = 4'd1,
        LOAD_BYTE  = 4'd2,
        LOAD_WRITE = 4'd3,
        DUMP_REQ   = 4'd4,
        DUMP_WAIT  = 4'd5,
        SEND_READY = 4'd6
    } state_t;

    localparam int NW = ADDR_WIDTH + 1;

    state_t                state_q, state_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  tx_start_q, tx_start_d;
    logic                  imem_we_q, imem_we_d;
    logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]           imem_wdata_q, imem_wdata_d;
    logic                  cpu_rst_q, cpu_rst_d;
    logic                  cpu_stall_q, cpu_stall_d;
    logic                  step_mode_q, step_mode_d;
    logic [2:0]            dump_sel_q, dump_sel_d;
    logic [6:0]            dump_idx_q, dump_idx_d, last_idx;
    logic                  running_q, running_d;
    logic                  halted_q, halted_d;
    logic                  sent_q, sent_d;
    logic                  step;
    logic [NW-1:0]         n_q, n_d, wcnt_q, wcnt_d;
    logic [1:0]            bcnt_q, bcnt_d;
    logic [23:0]           wbuf_q, wbuf_d;

    // index of the final byte of each dump source (length minus one)
    always_comb
        last_idx = (dump_sel_q == 3'd1) ? 7'd127 :
                   (dump_sel_q == 3'd2) ? 7'd7   :
                   (dump_sel_q == 3'd3) ? 7'd16  :
                   (dump_sel_q == 3'd4) ? 7'd9   : 7'd8;

    always_comb begin
        state_d      = state_q;
        tx_data_d    = tx_data_q;
        tx_start_d   = 1'b0;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        cpu_rst_d    = cpu_rst_q;
        step_mode_d  = step_mode_q;
        dump_sel_d   = dump_sel_q;
        dump_idx_d   = dump_idx_q;
        running_d    = running_q;
        halted_d     = halted_q || (i_halt && running_q);
        sent_d       = sent_q;
        step         = 1'b0;
        n_d          = n_q;
        wcnt_d       = wcnt_q;
        bcnt_d       = bcnt_q;
        wbuf_d       = wbuf_q;
        case (state_q)
            IDLE: if (i_rx_valid) begin
                case (i_rx_data)
                    8'h01, 8'h02, 8'h03, 8'h04, 8'h05: begin
                        dump_sel_d = i_rx_data[2:0];
                        dump_idx_d = 7'd0;
                        state_d    = DUMP_REQ;
                    end
                    8'h07: begin
                        cpu_rst_d = 1'b1;
                        running_d = 1'b0;
                        halted_d  = 1'b0;
                        state_d   = LOAD_CNT;
                    end
                    8'h08: begin
                        step_mode_d = 1'b0;
                        running_d   = running_q || !cpu_rst_q;
                    end
                    8'h09: step_mode_d = 1'b1;
                    8'h0A: step = running_q && step_mode_q && !halted_q;
                    8'h0B: running_d = 1'b0;
                    8'h0D: begin
                        cpu_rst_d = 1'b0;
                        running_d = 1'b1;
                    end
                    default: ;
                endcase
            end
            LOAD_CNT: if (i_rx_valid) begin
                n_d     = (32'(i_rx_data) > MAX_INSTRUCTION) ? NW'(MAX_INSTRUCTION) : NW'(i_rx_data);
                wcnt_d  = '0;
                bcnt_d  = 2'd0;
                state_d = (i_rx_data == 8'h00) ? SEND_READY : LOAD_BYTE;
            end
            // bytes shift in from the top so the first one lands in bits [7:0]
            LOAD_BYTE: if (i_rx_valid) begin
                wbuf_d = {i_rx_data, wbuf_q[23:8]};
                bcnt_d = bcnt_q + 2'd1;
                if (bcnt_q == 2'd3) begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = wcnt_q[ADDR_WIDTH-1:0];
                    imem_wdata_d = {i_rx_data, wbuf_q};
                    state_d      = LOAD_WRITE;
                end
            end
            LOAD_WRITE: begin
                wcnt_d  = wcnt_q + 1'b1;
                state_d = (wcnt_q == n_q - 1'b1) ? SEND_READY : LOAD_BYTE;
            end
            DUMP_REQ: begin
                tx_data_d  = i_dump_byte;
                tx_start_d = 1'b1;
                state_d    = DUMP_WAIT;
            end
            DUMP_WAIT: if (i_tx_done) begin
                dump_idx_d = dump_idx_q + 7'd1;
                state_d    = (dump_idx_q < last_idx) ? DUMP_REQ : SEND_READY;
            end
            SEND_READY: begin
                tx_data_d = 8'h52;
                if (!sent_q) begin
                    tx_start_d = 1'b1;
                    sent_d     = 1'b1;
                end else if (i_tx_done) begin
                    sent_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        cpu_stall_d = !((running_d && !step_mode_d && !halted_d) || step);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= IDLE;
            tx_data_q    <= 8'h00;
            tx_start_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= 32'h0;
            cpu_rst_q    <= 1'b1;
            cpu_stall_q  <= 1'b1;
            step_mode_q  <= 1'b0;
            dump_sel_q   <= 3'd0;
            dump_idx_q   <= 7'd0;
            running_q    <= 1'b0;
            halted_q     <= 1'b0;
            sent_q       <= 1'b0;
            n_q          <= '0;
            wcnt_q       <= '0;
            bcnt_q       <= 2'd0;
            wbuf_q       <= 24'h0;
        end else begin
            state_q      <= state_d;
            tx_data_q    <= tx_data_d;
            tx_start_q   <= tx_start_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_rst_q    <= cpu_rst_d;
            cpu_stall_q  <= cpu_stall_d;
            step_mode_q  <= step_mode_d;
            dump_sel_q   <= dump_sel_d;
            dump_idx_q   <= dump_idx_d;
            running_q    <= running_d;
            halted_q     <= halted_d;
            sent_q       <= sent_d;
            n_q          <= n_d;
            wcnt_q       <= wcnt_d;
            bcnt_q       <= bcnt_d;
            wbuf_q       <= wbuf_d;
        end
    end

    assign o_tx_data    = tx_data_q;
    assign o_tx_start   = tx_start_q;
    assign o_imem_we    = imem_we_q;
    assign o_imem_addr  = imem_addr_q;
    assign o_imem_wdata = imem_wdata_q;
    assign o_cpu_rst    = cpu_rst_q;
    assign o_cpu_stall  = cpu_stall_q;
    assign o_step_mode  = step_mode_q;
    assign o_dump_sel   = dump_sel_q;
    assign o_dump_idx   = dump_idx_q;
    assign o_state      = state_q;
endmodule

// File: tb/tb_debug_cmd_sequencer.sv
// tb_debug_cmd_sequencer: directed stimulus for load, step, run/halt, dump
// and mid-load reset, with a small transmitter and dump-source model.
module tb_debug_cmd_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  i_rx_data = 8'h00;
    logic        i_rx_valid = 1'b0;
    logic [7:0]  o_tx_data;
    logic        o_tx_start;
    logic        i_tx_done;
    logic        o_imem_we;
    logic [5:0]  o_imem_addr;
    logic [31:0] o_imem_wdata;
    logic        o_cpu_rst;
    logic        o_cpu_stall;
    logic        i_halt = 1'b0;
    logic [2:0]  o_dump_sel;
    logic [6:0]  o_dump_idx;
    logic [7:0]  i_dump_byte;
    logic        o_step_mode;
    logic [3:0]  o_state;

    always #5 clk = ~clk;

    debug_cmd_sequencer dut (
        .i_clk(clk), .i_rst(rst),
        .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
        .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_done(i_tx_done),
        .o_imem_we(o_imem_we), .o_imem_addr(o_imem_addr), .o_imem_wdata(o_imem_wdata),
        .o_cpu_rst(o_cpu_rst), .o_cpu_stall(o_cpu_stall), .i_halt(i_halt),
        .o_dump_sel(o_dump_sel), .o_dump_idx(o_dump_idx), .i_dump_byte(i_dump_byte),
        .o_step_mode(o_step_mode), .o_state(o_state)
    );

    // dump source model: byte = {sel, 00000} ^ idx
    assign i_dump_byte = {o_dump_sel, 5'd0} ^ {1'b0, o_dump_idx};

    int          n_chk = 0;
    int          n_pass = 0;
    logic [5:0]  we_addr[$];
    logic [31:0] we_data[$];
    logic [7:0]  tx_byte[$];
    logic [6:0]  tx_idx[$];
    int          stall_lo = 0;
    int          windows = 0;
    logic        prev_stall = 1'b1;

    always @(negedge clk) begin
        if (o_imem_we) begin
            we_addr.push_back(o_imem_addr);
            we_data.push_back(o_imem_wdata);
        end
        if (o_tx_start) begin
            tx_byte.push_back(o_tx_data);
            tx_idx.push_back(o_dump_idx);
        end
        if (!o_cpu_stall) stall_lo <= stall_lo + 1;
        if (!o_cpu_stall && prev_stall) windows <= windows + 1;
        prev_stall <= o_cpu_stall;
    end

    // transmitter model: finishes each byte 4 cycles after the request
    initial begin
        i_tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (o_tx_start) begin
                repeat (3) @(negedge clk);
                i_tx_done = 1'b1;
                @(negedge clk);
                i_tx_done = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        @(negedge clk);
        i_rx_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 3000 && o_state != 4'd0; i++) @(negedge clk);
        check(tag, 32'(o_state), 0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_state"}, 32'(o_state), 0);
        check({tag, "_tx_start"}, 32'(o_tx_start), 0);
        check({tag, "_tx_data"}, 32'(o_tx_data), 0);
        check({tag, "_we"}, 32'(o_imem_we), 0);
        check({tag, "_addr"}, 32'(o_imem_addr), 0);
        check({tag, "_wdata"}, o_imem_wdata, 0);
        check({tag, "_cpu_rst"}, 32'(o_cpu_rst), 1);
        check({tag, "_stall"}, 32'(o_cpu_stall), 1);
        check({tag, "_step_mode"}, 32'(o_step_mode), 0);
        check({tag, "_dump_sel"}, 32'(o_dump_sel), 0);
        check({tag, "_dump_idx"}, 32'(o_dump_idx), 0);
    endtask

    initial begin
        int s0, w0, q0, t0;
        repeat (2) @(negedge clk);
        check_reset("por");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // step before start is ignored, then three single-cycle step windows
        s0 = stall_lo;
        w0 = windows;
        send(8'h09);
        check("step_mode_set", 32'(o_step_mode), 1);
        send(8'h0A);
        check("step_before_start", 32'(stall_lo - s0), 0);
        send(8'h0D);
        check("start_cpu_rst", 32'(o_cpu_rst), 0);
        check("start_step_stall", 32'(o_cpu_stall), 1);
        @(negedge clk);
        i_rx_data  = 8'h0A;
        i_rx_valid = 1'b1;
        @(negedge clk);
        i_rx_valid = 1'b0;
        check("step_window_open", 32'(o_cpu_stall), 0);
        @(negedge clk);
        check("step_window_close", 32'(o_cpu_stall), 1);
        send(8'h0A);
        send(8'h0A);
        check("step_windows", 32'(windows - w0), 3);
        check("step_low_cycles", 32'(stall_lo - s0), 3);

        // two-word load
        q0 = we_addr.size();
        t0 = tx_byte.size();
        send(8'h07);
        check("load_cpu_rst", 32'(o_cpu_rst), 1);
        send(8'h02);
        send(8'h0F); send(8'h00); send(8'h01); send(8'h20);
        send(8'h00); send(8'h00); send(8'h00); send(8'h00);
        wait_idle("load2_idle");
        check("load2_writes", 32'(we_addr.size() - q0), 2);
        if (we_addr.size() >= q0 + 2) begin
            check("load2_addr0", 32'(we_addr[q0]), 0);
            check("load2_data0", we_data[q0], 32'h2001000F);
            check("load2_addr1", 32'(we_addr[q0+1]), 1);
            check("load2_data1", we_data[q0+1], 32'h00000000);
        end
        check("load2_tx_count", 32'(tx_byte.size() - t0), 1);
        if (tx_byte.size() > t0) check("load2_ready", 32'(tx_byte[t0]), 32'h52);
        check("load2_cpu_rst_held", 32'(o_cpu_rst), 1);
        check("load2_stall", 32'(o_cpu_stall), 1);

        // N=0x50 clamps to 64 words
        q0 = we_addr.size();
        t0 = tx_byte.size();
        send(8'h07);
        send(8'h50);
        for (int j = 0; j < 256; j++) send(8'(j));
        wait_idle("clamp_idle");
        check("clamp_writes", 32'(we_addr.size() - q0), 64);
        if (we_addr.size() >= q0 + 64)
            for (int k = 0; k < 64; k++) begin
                check("clamp_addr", 32'(we_addr[q0+k]), 32'(k));
                check("clamp_data", we_data[q0+k],
                      {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});
            end
        check("clamp_tx_count", 32'(tx_byte.size() - t0), 1);
        if (tx_byte.size() > t0) check("clamp_ready", 32'(tx_byte[t0]), 32'h52);

        // N=0 answers immediately
        q0 = we_addr.size();
        t0 = tx_byte.size();
        send(8'h07);
        send(8'h00);
        wait_idle("zero_idle");
        check("zero_writes", 32'(we_addr.size() - q0), 0);
        check("zero_tx_count", 32'(tx_byte.size() - t0), 1);
        if (tx_byte.size() > t0) check("zero_ready", 32'(tx_byte[t0]), 32'h52);

        // ID/EX dump with a dropped command in the middle
        t0 = tx_byte.size();
        send(8'h03);
        send(8'h01);
        wait_idle("dump3_idle");
        check("dump3_tx_count", 32'(tx_byte.size() - t0), 18);
        check("dump3_sel", 32'(o_dump_sel), 3);
        if (tx_byte.size() >= t0 + 18) begin
            for (int k = 0; k < 17; k++) begin
                check("dump3_byte", 32'(tx_byte[t0+k]), 32'({3'd3, 5'd0} ^ {1'b0, 7'(k)}));
                check("dump3_idx", 32'(tx_idx[t0+k]), 32'(k));
            end
            check("dump3_ready", 32'(tx_byte[t0+17]), 32'h52);
        end
        check("dump3_cpu_rst", 32'(o_cpu_rst), 1);

        // continuous run, halt, then an ignored step
        send(8'h0D);
        send(8'h08);
        check("run_step_mode", 32'(o_step_mode), 0);
        check("run_stall", 32'(o_cpu_stall), 0);
        @(negedge clk);
        i_halt = 1'b1;
        @(negedge clk);
        i_halt = 1'b0;
        check("halt_stall", 32'(o_cpu_stall), 1);
        s0 = stall_lo;
        send(8'h09);
        send(8'h0A);
        repeat (5) @(negedge clk);
        check("halt_step_ignored", 32'(stall_lo - s0), 0);
        check("halt_stall_held", 32'(o_cpu_stall), 1);

        // reset mid-load, then a full register dump
        send(8'h07);
        send(8'h02);
        send(8'h11);
        send(8'h22);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset("midload");
        q0 = we_addr.size();
        t0 = tx_byte.size();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        send(8'h01);
        wait_idle("dump1_idle");
        check("dump1_tx_count", 32'(tx_byte.size() - t0), 129);
        if (tx_byte.size() >= t0 + 129) begin
            for (int k = 0; k < 128; k++)
                check("dump1_byte", 32'(tx_byte[t0+k]), 32'({3'd1, 5'd0} ^ {1'b0, 7'(k)}));
            check("dump1_ready", 32'(tx_byte[t0+128]), 32'h52);
        end
        check("midload_no_writes", 32'(we_addr.size() - q0), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
